tdm_mux: RTL and testbench
==========================

TDM_MUX -- requirements
Module: tdm_mux

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, range 2..16.
REQ-002 Parameter DW, default 1: bits per channel.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk_in  input  1  clock; all state updates on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 d_in  input  N_CH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
REQ-007 mode_in  input  1  0 = manual select, 1 = auto round-robin scan.
REQ-008 sel_in  input  clog2(N_CH)  channel index, used in manual mode only.
REQ-009 en_mask_in  input  N_CH  per-channel enable; bit k = 1 means channel k is eligible.
REQ-010 ready_in  input  1  downstream accepts the current beat.
REQ-011 y_out  output  DW  registered data of the selected channel.
REQ-012 valid_out  output  1  y_out/ch_out hold a beat.
REQ-013 ch_out  output  clog2(N_CH)  index of the channel carried in y_out.
REQ-014 sof_out  output  1  start-of-frame flag, qualified by valid_out.

Function
REQ-015 Capture condition ("slot free") SHALL be: valid_out==0 or ready_in==1, sampled at the clock edge.
REQ-016 While valid_out==1 and ready_in==0, y_out, ch_out, sof_out and valid_out SHALL hold unchanged; inputs are ignored.
REQ-017 Latency SHALL be exactly 1 cycle from capture edge to data on y_out; no combinational input-to-output path.
REQ-018 Manual mode, slot free: y_out<=d_in[sel_in]; ch_out<=sel_in; sof_out<=0; valid_out<=en_mask_in[sel_in].
REQ-019 Manual mode: sel_in >= N_CH SHALL be treated as disabled (valid_out<=0, y_out unchanged).
REQ-020 Auto mode, slot free: search for the first enabled channel in the order ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
REQ-021 Auto mode, channel k found: y_out<=d_in[k]; ch_out<=k; valid_out<=1; ptr<=(k+1) mod N_CH.
REQ-022 Auto mode: sof_out<=1 when k <= the previously captured auto-mode index, or when this is the first auto beat since reset or since mode_in rose; otherwise sof_out<=0.
REQ-023 Auto mode, en_mask_in all zero: valid_out<=0; ptr, y_out and ch_out unchanged.
REQ-024 A 0->1 transition of mode_in SHALL reset ptr to 0 at the next capture, and that capture is the first auto beat.
REQ-025 A mode change while a beat is stalled SHALL NOT disturb the held beat; the new mode applies at the next capture.
REQ-026 Mask changes SHALL take effect at the next capture only; a held beat is never withdrawn.
REQ-027 ptr SHALL wrap from N_CH-1 to 0 for non-power-of-two N_CH, never reaching indices >= N_CH.

Reset
REQ-028 On rst_in high, immediately and regardless of the clock: y_out=0, valid_out=0, ch_out=0, sof_out=0, ptr=0, first-auto flag set.
REQ-029 Reset asserted mid-stall SHALL discard the held beat; the first capture after release follows REQ-015..024.

Structure
REQ-030 A shared package SHALL hold the mode encodings (MODE_MANUAL=0, MODE_AUTO=1) and the index-width function.
REQ-031 A sub-module rr_pick SHALL implement the combinational rotate-and-priority search (mask, ptr -> found, k, wrapped).
REQ-032 tdm_mux SHALL contain only the capture register, ptr/flag state and mode muxing.

Verification
REQ-033 Manual, N_CH=4, DW=8, d_in=0x44_33_22_11, mask=4'hF, sel_in=2, ready=1 -> next cycle y_out=0x33, ch_out=2, valid_out=1, sof_out=0.
REQ-034 Auto, mask=4'b1011, ready=1 for 6 cycles -> ch_out sequence 0,1,3,0,1,3; sof_out=1 on each ch 0 beat.
REQ-035 Auto, ready=0 for 3 cycles with ch_out=1 held -> y_out/ch_out stable; after ready=1, next beat is ch 3.
REQ-036 Auto, mask=0 -> valid_out=0 within 1 cycle; mask restored to 4'b0100 -> ch_out=2, valid_out=1.
REQ-037 N_CH=3, manual sel_in=3 -> valid_out=0; auto with full mask -> ch_out 0,1,2,0 wrap.
REQ-038 rst_in pulsed mid-stall, asynchronously to the clock -> all outputs 0 immediately; first auto beat after release has ch_out=0, sof_out=1.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the TDM multiplexer: mode encodings and index sizing.
package tdm_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Width of a channel index; at least one bit even for two channels.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_mux_rr_pick.sv
// Combinational round-robin search: first set mask bit at or after ptr, wrapping.
module rr_pick
  import tdm_mux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int IW = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   k,
  output logic            wrapped
);

  function automatic int rot(input logic [IW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= N_CH) s = s - N_CH;
    return s;
  endfunction

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found   = 1'b0;
    k       = '0;
    wrapped = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[IW'(rot(ptr, i))]) begin
        found   = 1'b1;
        k       = IW'(rot(ptr, i));
        wrapped = (rot(ptr, i) < int'(ptr));
      end
    end
  end

endmodule

// File: rtl/tdm_mux.sv
// TDM multiplexer: one registered beat slot fed by a manual selector or a
// round-robin scan, with ready/valid back-pressure and start-of-frame marking.
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 1,
  localparam int IW  = idx_w(N_CH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [N_CH*DW-1:0]   d_in,
  input  logic                 mode_in,
  input  logic [IW-1:0]        sel_in,
  input  logic [N_CH-1:0]      en_mask_in,
  input  logic                 ready_in,
  output logic [DW-1:0]        y_out,
  output logic                 valid_out,
  output logic [IW-1:0]        ch_out,
  output logic                 sof_out
);

  logic [IW-1:0] ptr;
  logic          first_auto;
  logic          slot_free;
  logic          auto_mode;
  logic [IW-1:0] ptr_eff;
  logic          pick_found;
  logic [IW-1:0] pick_k;
  logic          pick_wrapped;
  logic          sel_ok;
  logic          manual_en;

  function automatic logic [DW-1:0] ch_data(input logic [N_CH*DW-1:0] d,
                                            input logic [IW-1:0] idx);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++)
      if (idx == IW'(i)) r = d[i*DW +: DW];
    return r;
  endfunction

  assign slot_free = !valid_out || ready_in;
  assign auto_mode = (mode_e'(mode_in) == MODE_AUTO);
  // A pending first auto beat restarts the scan at channel 0.
  assign ptr_eff   = first_auto ? '0 : ptr;
  assign sel_ok    = ({1'b0, sel_in} < (IW+1)'(N_CH));
  assign manual_en = sel_ok && |(en_mask_in & (N_CH'(1) << sel_in));

  rr_pick #(.N_CH(N_CH)) u_rr_pick (
    .mask    (en_mask_in),
    .ptr     (ptr_eff),
    .found   (pick_found),
    .k       (pick_k),
    .wrapped (pick_wrapped)
  );

  // Capture register: the only stage between inputs and outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      y_out      <= '0;
      valid_out  <= 1'b0;
      ch_out     <= '0;
      sof_out    <= 1'b0;
      ptr        <= '0;
      first_auto <= 1'b1;
    end else begin
      // Any cycle spent in manual mode makes the next auto beat a fresh frame.
      if (!auto_mode) first_auto <= 1'b1;
      if (slot_free) begin
        if (!auto_mode) begin
          sof_out <= 1'b0;
          if (sel_ok) begin
            y_out     <= ch_data(d_in, sel_in);
            ch_out    <= sel_in;
            valid_out <= manual_en;
          end else begin
            valid_out <= 1'b0;
          end
        end else if (pick_found) begin
          y_out      <= ch_data(d_in, pick_k);
          ch_out     <= pick_k;
          valid_out  <= 1'b1;
          // k <= previous index is equivalent to wrapping past the end or ptr at 0.
          sof_out    <= pick_wrapped || (ptr_eff == '0);
          ptr        <= (pick_k == IW'(N_CH - 1)) ? '0 : pick_k + 1'b1;
          first_auto <= 1'b0;
        end else begin
          valid_out <= 1'b0;
          sof_out   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Randomized and directed bench for tdm_mux (4x8-bit and 3x4-bit instances)
// against a behavioural frame/scan model.
module tb_tdm_mux;

  typedef struct {
    logic [7:0] y;
    int         ch;
    bit         valid;
    bit         sof;
    int         ptr;
    bit         first;
    int         last_k;
    bit         prev_mode;
  } mstate_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        mode_in = 1'b0;
  logic [1:0]  sel_in = '0;
  logic [3:0]  mask = '0;
  logic        ready_in = 1'b0;
  logic [31:0] d4 = '0;
  logic [11:0] d3 = '0;

  logic [7:0]  y4;
  logic        v4, s4;
  logic [1:0]  ch4;
  logic [3:0]  y3;
  logic        v3, s3;
  logic [1:0]  ch3;

  int n_checks = 0;
  int n_fail   = 0;
  mstate_t m4, m3;

  always #5 clk_in = ~clk_in;

  tdm_mux #(.N_CH(4), .DW(8)) u_dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(d4), .mode_in(mode_in),
    .sel_in(sel_in), .en_mask_in(mask), .ready_in(ready_in),
    .y_out(y4), .valid_out(v4), .ch_out(ch4), .sof_out(s4)
  );

  tdm_mux #(.N_CH(3), .DW(4)) u_dut3 (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(d3), .mode_in(mode_in),
    .sel_in(sel_in), .en_mask_in(mask[2:0]), .ready_in(ready_in),
    .y_out(y3), .valid_out(v3), .ch_out(ch3), .sof_out(s3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t r;
    r.y = '0; r.ch = 0; r.valid = 0; r.sof = 0; r.ptr = 0;
    r.first = 1; r.last_k = 0; r.prev_mode = 0;
    return r;
  endfunction

  function automatic logic [7:0] chan(input logic [31:0] d, input int dw, input int k);
    logic [31:0] m;
    m = (32'd1 << dw) - 1;
    return 8'((d >> (k * dw)) & m);
  endfunction

  // Behavioural model of one clock edge.
  function automatic mstate_t mstep(input mstate_t s, input int n, input int dw,
                                    input logic [31:0] d, input bit mode, input int sel,
                                    input logic [3:0] msk, input bit rdy);
    mstate_t r;
    bit first_now;
    int start, k;
    r = s;
    first_now = s.first || (mode && !s.prev_mode);
    r.prev_mode = mode;
    r.first = first_now;
    if (!s.valid || rdy) begin
      if (!mode) begin
        r.sof = 0;
        if (sel < n) begin
          r.y = chan(d, dw, sel); r.ch = sel; r.valid = msk[sel];
        end else begin
          r.valid = 0;
        end
      end else begin
        start = first_now ? 0 : s.ptr;
        k = -1;
        for (int off = 0; off < n; off++)
          if (k < 0 && msk[(start + off) % n]) k = (start + off) % n;
        if (k >= 0) begin
          r.y = chan(d, dw, k); r.ch = k; r.valid = 1;
          r.sof = first_now || (k <= s.last_k);
          r.last_k = k; r.ptr = (k + 1) % n; r.first = 0;
        end else begin
          r.valid = 0; r.sof = 0;
        end
      end
    end
    return r;
  endfunction

  task automatic compare_all();
    check("valid4", 32'(v4), 32'(m4.valid));
    check("ch4", 32'(ch4), 32'(m4.ch));
    check("y4", 32'(y4), 32'(m4.y));
    if (m4.valid) check("sof4", 32'(s4), 32'(m4.sof));
    check("valid3", 32'(v3), 32'(m3.valid));
    check("ch3", 32'(ch3), 32'(m3.ch));
    check("y3", 32'(y3), 32'(m3.y));
    if (m3.valid) check("sof3", 32'(s3), 32'(m3.sof));
  endtask

  task automatic step();
    @(posedge clk_in);
    if (!rst_in) begin
      m4 = mstep(m4, 4, 8, d4, mode_in, int'(sel_in), mask, ready_in);
      m3 = mstep(m3, 3, 4, {20'b0, d3}, mode_in, int'(sel_in), mask, ready_in);
    end
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_v4"}, 32'(v4), 0);
    check({tag, "_ch4"}, 32'(ch4), 0);
    check({tag, "_y4"}, 32'(y4), 0);
    check({tag, "_s4"}, 32'(s4), 0);
    check({tag, "_v3"}, 32'(v3), 0);
    check({tag, "_y3"}, 32'(y3), 0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset(input int dly);
    #(dly) rst_in = 1'b1;
    #1;
    m4 = mreset();
    m3 = mreset();
    check_zero("async_rst");
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    logic [7:0] held_y;
    int exp_ch[6];
    bit exp_sof[6];
    exp_ch  = '{0, 1, 3, 0, 1, 3};
    exp_sof = '{1, 0, 0, 1, 0, 0};
    m4 = mreset();
    m3 = mreset();

    @(negedge clk_in);
    check_zero("por");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Manual select of channel 2.
    d4 = 32'h4433_2211; d3 = 12'h321; mask = 4'hF; sel_in = 2'd2;
    mode_in = 1'b0; ready_in = 1'b1;
    step();
    check("man_y", 32'(y4), 32'h33);
    check("man_ch", 32'(ch4), 2);
    check("man_v", 32'(v4), 1);
    check("man_sof", 32'(s4), 0);

    // Auto scan over mask 1011.
    mode_in = 1'b1; mask = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      d4 = $urandom; d3 = 12'($urandom);
      step();
      check("rr_ch", 32'(ch4), 32'(exp_ch[i]));
      check("rr_sof", 32'(s4), 32'(exp_sof[i]));
    end
    step();
    step();
    check("pre_stall_ch", 32'(ch4), 1);
    held_y = y4;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d4 = $urandom; mask = 4'($urandom);
      step();
      check("stall_ch", 32'(ch4), 1);
      check("stall_y", 32'(y4), 32'(held_y));
      check("stall_v", 32'(v4), 1);
    end
    mask = 4'b1011; ready_in = 1'b1;
    step();
    check("post_stall_ch", 32'(ch4), 3);

    // Empty mask then a single channel.
    mask = 4'b0000;
    step();
    check("mask0_v", 32'(v4), 0);
    mask = 4'b0100;
    step();
    check("mask4_ch", 32'(ch4), 2);
    check("mask4_v", 32'(v4), 1);

    // Three-channel instance: out-of-range select, then wrapping scan.
    mode_in = 1'b0; sel_in = 2'd3; mask = 4'hF;
    step();
    check("n3_sel3_v", 32'(v3), 0);
    mode_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("n3_rr_ch", 32'(ch3), 32'(i % 3));
    end

    // Reset during a stall.
    ready_in = 1'b0;
    step();
    check("pre_rst_v", 32'(v4), 1);
    async_reset(3);
    ready_in = 1'b1; mask = 4'b1110;
    mask = 4'hF;
    step();
    check("rst_first_ch", 32'(ch4), 0);
    check("rst_first_sof", 32'(s4), 1);
    check("rst_first_v", 32'(v4), 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) mode_in = ~mode_in;
      ready_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) mask = 4'($urandom);
      sel_in = 2'($urandom);
      d4 = $urandom;
      d3 = 12'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset($urandom_range(1, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
